brush_stamper: RTL and testbench
================================

BRUSH_STAMPER -- requirements
Module: brush_stamper

Interface
REQ-001 Parameter COORD_W, default 7, is the frame buffer coordinate width (128x128 canvas).
REQ-002 Parameter RADIUS_W, default 2, is the brush radius width (radius 0..3).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  stamp request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_x, req_y  input  8 each  brush centre coordinate, unsigned.
REQ-008 req_color  input  3  colour code from colors.svh.
REQ-009 req_radius  input  RADIUS_W  brush radius r.
REQ-010 brush  output  1  pixel-store write strobe.
REQ-011 wx, wy  output  8 each  write coordinate; upper bits above COORD_W are always 0.
REQ-012 newColor  output  3  write colour.
REQ-013 busy  output  1  stamp in progress.

Function
REQ-014 The block SHALL use two states: IDLE and STAMP.
REQ-015 In IDLE, req_ready SHALL be 1; in STAMP, req_ready SHALL be 0 (decoded from state).
REQ-016 A request SHALL be accepted on the posedge where req_valid=1 and req_ready=1. On acceptance, x, y, colour and r SHALL be latched, dx=dy=-r SHALL be set, and the state SHALL move to STAMP.
REQ-017 In STAMP, exactly one candidate (x+dx, y+dy) SHALL be evaluated per cycle. Order is row-major: dx runs -r..r inside dy, which runs -r..r.
REQ-018 Candidate arithmetic SHALL be signed, at least COORD_W+3 bits wide, with no wrap-around.
REQ-019 A candidate with both coordinates in 0..2^COORD_W-1 SHALL produce one registered cycle of brush=1, with wx/wy set to the candidate and newColor set to the latched colour.
REQ-020 A candidate outside that range SHALL produce brush=0 for its cycle but still consume the cycle (clipping).
REQ-021 brush SHALL assert in the cycle after acceptance, giving a first-write latency of 1.
REQ-022 A stamp SHALL occupy exactly (2r+1)^2 cycles in STAMP. r=0 SHALL give a single write at (x,y).
REQ-023 After the candidate dx=dy=r, the state SHALL return to IDLE, and req_ready=1 in the following cycle. The minimum spacing between acceptances is (2r+1)^2+1 cycles.
REQ-024 busy SHALL equal 1 exactly while in STAMP.
REQ-025 When brush=0, wx, wy and newColor SHALL hold their previous values.
REQ-026 Input changes during STAMP SHALL be ignored. req_valid held high during STAMP SHALL be accepted only once back in IDLE.

Reset
REQ-027 While reset=0 at a posedge, the state SHALL become IDLE and brush, busy, wx, wy and newColor SHALL become 0.
REQ-028 Reset asserted mid-stamp SHALL abort the stamp: no further brush=1 SHALL occur, and the aborted request SHALL NOT resume.
REQ-029 req_ready SHALL be 1 from the first cycle after reset deasserts.

Configuration
REQ-030 Macro BRUSH_ROUND_EN selects the brush shape.
- When defined: a candidate with dx^2+dy^2 > r^2+r SHALL be suppressed (brush=0, cycle still consumed), giving a rounded brush.
- When undefined: every in-range candidate of the full square SHALL be written.
- Cycle count (REQ-022) is identical in both builds.

Verification
REQ-031 After reset, req x=10, y=20, r=0, colour=green -> brush=1 for exactly 1 cycle at (10,20), one cycle after acceptance; req_ready returns to 1 two cycles after acceptance.
REQ-032 req x=64, y=64, r=1, colour=red -> 9 writes in order (63,63),(64,63),(65,63),(63,64),...,(65,65); busy high for 9 cycles.
REQ-033 req x=0, y=127, r=2 -> 25 STAMP cycles, of which 9 write (x 0..2, y 125..127); no write with a coordinate >127 or wrapped.
REQ-034 req x=64, y=64, r=3 -> 49 writes without BRUSH_ROUND_EN; with the macro, 37 writes and no write at (61,61) or (67,62).
REQ-035 req_valid held high with two different requests queued back-to-back -> the second is accepted only after the first finishes; the first's colour/coords are unaffected by input changes mid-stamp.
REQ-036 reset=0 pulsed on the 4th STAMP cycle of an r=2 stamp -> brush=0 and busy=0 from the next cycle; req_ready=1 after reset; no residual writes.

Source files
------------

// File: rtl/brush_stamper.sv
// -----------------------------------------------------------------------------
// brush_stamper
//
// Stamps a square (or optionally rounded) brush of radius r centred on
// (req_x, req_y) into a 2^COORD_W x 2^COORD_W pixel store. One candidate
// pixel is visited per cycle in row-major order (dx inner, dy outer, both
// running -r..r). Candidates that fall off the canvas are clipped: they still
// take their cycle but produce no write strobe.
//
// Optional feature macro: BRUSH_ROUND_EN
//   defined   -> candidates with dx^2+dy^2 > r^2+r are suppressed (round brush)
//   undefined -> every on-canvas candidate of the square is written
//   The cycle count per stamp is the same in both builds.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-low reset
//   req_valid   stamp request present
//   req_ready   high while idle; a request is taken when valid & ready
//   req_x/y     brush centre, unsigned 8 bit
//   req_color   3-bit colour code (opaque to this block)
//   req_radius  brush radius r
//   brush       registered pixel-store write strobe
//   wx/wy       write coordinate, held while brush is low
//   newColor    write colour, held while brush is low
//   busy        high for every cycle of a stamp
// -----------------------------------------------------------------------------
module brush_stamper #(
    parameter int COORD_W  = 7,
    parameter int RADIUS_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_x,
    input  logic [7:0]          req_y,
    input  logic [2:0]          req_color,
    input  logic [RADIUS_W-1:0] req_radius,
    output logic                brush,
    output logic [7:0]          wx,
    output logic [7:0]          wy,
    output logic [2:0]          newColor,
    output logic                busy
);

    // Signed working width: wide enough for an 8-bit centre plus/minus the
    // largest radius with headroom, so candidates never wrap.
    localparam int BASE_W = (COORD_W > 8) ? COORD_W : 8;
    localparam int SW     = ((BASE_W > RADIUS_W) ? BASE_W : RADIUS_W) + 3;

    localparam logic signed [SW-1:0] ZERO_C      = {SW{1'b0}};
    localparam logic signed [SW-1:0] ONE_C       = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] MAX_COORD_C = SW'((64'd1 << COORD_W) - 64'd1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STAMP = 1'b1
    } state_t;

    function automatic logic signed [SW-1:0] ext_coord(input logic [7:0] v);
        ext_coord = $signed({{(SW-8){1'b0}}, v});
    endfunction

    function automatic logic signed [SW-1:0] ext_rad(input logic [RADIUS_W-1:0] v);
        ext_rad = $signed({{(SW-RADIUS_W){1'b0}}, v});
    endfunction

    state_t                 state_r, state_nx_s;
    logic [7:0]             x_r, y_r;
    logic [2:0]             color_r;
    logic [RADIUS_W-1:0]    rad_r;
    logic signed [SW-1:0]   dx_r, dy_r, dx_nx_s, dy_nx_s;
    logic signed [SW-1:0]   base_x_s, base_y_s, rad_s;
    logic signed [SW-1:0]   cand_x_s, cand_y_s;
    logic [2:0]             color_s;
    logic                   load_s, emit_s, in_range_s, shape_ok_s;
    logic                   brush_r;
    logic [7:0]             wx_r, wy_r;
    logic [2:0]             color_out_r;

    // Next state and next candidate offsets. The brush output is registered
    // together with the offsets, so the candidate written in a cycle is the
    // one whose offsets are held in dx_r/dy_r during that cycle.
    always_comb begin
        state_nx_s = state_r;
        dx_nx_s    = dx_r;
        dy_nx_s    = dy_r;
        base_x_s   = ext_coord(x_r);
        base_y_s   = ext_coord(y_r);
        rad_s      = ext_rad(rad_r);
        color_s    = color_r;
        load_s     = 1'b0;
        emit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nx_s = STAMP;
                    load_s     = 1'b1;
                    emit_s     = 1'b1;
                    base_x_s   = ext_coord(req_x);
                    base_y_s   = ext_coord(req_y);
                    rad_s      = ext_rad(req_radius);
                    color_s    = req_color;
                    dx_nx_s    = -ext_rad(req_radius);
                    dy_nx_s    = -ext_rad(req_radius);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            STAMP: begin
                if ((dx_r == rad_s) && (dy_r == rad_s)) begin
                    state_nx_s = IDLE;
                end else if (dx_r == rad_s) begin
                    dx_nx_s = -rad_s;
                    dy_nx_s = dy_r + ONE_C;
                    emit_s  = 1'b1;
                end else begin
                    dx_nx_s = dx_r + ONE_C;
                    emit_s  = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Candidate coordinate, canvas clipping and optional round-brush mask.
`ifdef BRUSH_ROUND_EN
    logic signed [2*SW-1:0] dxw_s, dyw_s, radw_s, dist_s, lim_s;
`endif
    always_comb begin
        cand_x_s   = base_x_s + dx_nx_s;
        cand_y_s   = base_y_s + dy_nx_s;
        in_range_s = (cand_x_s >= ZERO_C) && (cand_x_s <= MAX_COORD_C) &&
                     (cand_y_s >= ZERO_C) && (cand_y_s <= MAX_COORD_C);
`ifdef BRUSH_ROUND_EN
        dxw_s      = {{SW{dx_nx_s[SW-1]}}, dx_nx_s};
        dyw_s      = {{SW{dy_nx_s[SW-1]}}, dy_nx_s};
        radw_s     = {{SW{rad_s[SW-1]}}, rad_s};
        dist_s     = dxw_s * dxw_s + dyw_s * dyw_s;
        lim_s      = radw_s * radw_s + radw_s;
        shape_ok_s = (dist_s <= lim_s);
`else
        shape_ok_s = 1'b1;
`endif
    end

    // State, latched request and registered write outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            x_r         <= 8'd0;
            y_r         <= 8'd0;
            color_r     <= 3'd0;
            rad_r       <= {RADIUS_W{1'b0}};
            dx_r        <= ZERO_C;
            dy_r        <= ZERO_C;
            brush_r     <= 1'b0;
            wx_r        <= 8'd0;
            wy_r        <= 8'd0;
            color_out_r <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            dx_r    <= dx_nx_s;
            dy_r    <= dy_nx_s;
            if (load_s) begin
                x_r     <= req_x;
                y_r     <= req_y;
                color_r <= req_color;
                rad_r   <= req_radius;
            end
            if (emit_s && in_range_s && shape_ok_s) begin
                brush_r     <= 1'b1;
                wx_r        <= cand_x_s[7:0];
                wy_r        <= cand_y_s[7:0];
                color_out_r <= color_s;
            end else begin
                brush_r <= 1'b0;
            end
        end
    end

    assign req_ready = (state_r == IDLE);
    assign busy      = (state_r == STAMP);
    assign brush     = brush_r;
    assign wx        = wx_r;
    assign wy        = wy_r;
    assign newColor  = color_out_r;

endmodule

// File: tb/tb_brush_stamper.sv
// -----------------------------------------------------------------------------
// Testbench for brush_stamper. The driver issues stamps and pushes the list of
// per-cycle expected results (write or clipped, coordinate, colour) computed
// from plain nested loops over the brush square. A separate monitor pops one
// entry per busy cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_brush_stamper;

    localparam int COORD_W  = 7;
    localparam int RADIUS_W = 2;
    localparam int CANVAS   = 1 << COORD_W;

    localparam logic [2:0] C_RED    = 3'd4;
    localparam logic [2:0] C_GREEN  = 3'd2;
    localparam logic [2:0] C_BLUE   = 3'd1;
    localparam logic [2:0] C_YELLOW = 3'd6;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [7:0]          req_x, req_y;
    logic [2:0]          req_color;
    logic [RADIUS_W-1:0] req_radius;
    logic                brush;
    logic [7:0]          wx, wy;
    logic [2:0]          newColor;
    logic                busy;

    brush_stamper #(.COORD_W(COORD_W), .RADIUS_W(RADIUS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .req_radius (req_radius),
        .brush      (brush),
        .wx         (wx),
        .wy         (wy),
        .newColor   (newColor),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: every candidate of the square in row-major order.
    task automatic push_model(input int x, input int y, input logic [2:0] c, input int r);
        exp_t e;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                int cx = x + dx;
                int cy = y + dy;
                bit ok = (cx >= 0) && (cx < CANVAS) && (cy >= 0) && (cy < CANVAS);
`ifdef BRUSH_ROUND_EN
                if (dx * dx + dy * dy > r * r + r) ok = 1'b0;
`endif
                e.wr = ok;
                e.x  = 8'(cx);
                e.y  = 8'(cy);
                e.c  = c;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: one expected entry per busy cycle; no strobe while idle.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("busy_extra_cycle", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("brush", 32'(brush), 32'(mon_e.wr));
                    if (mon_e.wr) begin
                        check("wx", 32'(wx), 32'(mon_e.x));
                        check("wy", 32'(wy), 32'(mon_e.y));
                        check("newColor", 32'(newColor), 32'(mon_e.c));
                    end
                end
            end else begin
                check("idle_brush", 32'(brush), 32'd0);
            end
            if (brush) n_writes++;
        end
    end

    // Present a request at a negedge and wait (bounded) for its acceptance.
    // Returns at the negedge of the first STAMP cycle.
    task automatic issue(input int x, input int y, input logic [2:0] c, input int r, output bit ok);
        req_x      = 8'(x);
        req_y      = 8'(y);
        req_color  = c;
        req_radius = RADIUS_W'(r);
        req_valid  = 1'b1;
        ok         = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            push_model(x, y, c, r);
            @(posedge clk);
            @(negedge clk);
            check("busy_after_accept", 32'(busy), 32'd1);
            check("ready_after_accept", 32'(req_ready), 32'd0);
        end
    endtask

    // Ride out the rest of an n-cycle stamp, optionally scrambling inputs,
    // then confirm the block is idle and every expected entry was consumed.
    task automatic tail(input int n, input bit junk);
        for (int k = 1; k <= n; k++) begin
            if (junk) begin
                req_x      = 8'($urandom);
                req_y      = 8'($urandom);
                req_color  = 3'($urandom);
                req_radius = RADIUS_W'($urandom);
                req_valid  = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(req_ready), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input int x, input int y, input logic [2:0] c, input int r);
        bit ok;
        n_writes = 0;
        issue(x, y, c, r, ok);
        if (ok) tail((2 * r + 1) * (2 * r + 1), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_x      = 8'd0;
        req_y      = 8'd0;
        req_color  = 3'd0;
        req_radius = '0;
        repeat (3) @(negedge clk);
        check("rst_brush", 32'(brush), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wx", 32'(wx), 32'd0);
        check("rst_wy", 32'(wy), 32'd0);
        check("rst_color", 32'(newColor), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Single pixel, latency and turnaround.
        run(10, 20, C_GREEN, 0);
        check("r0_writes", 32'(n_writes), 32'd1);

        // 3x3 fully on canvas.
        run(64, 64, C_RED, 1);
        check("r1_writes", 32'(n_writes), 32'd9);

        // Corner clipping: only x 0..2, y 125..127 survive.
        run(0, 127, C_BLUE, 2);
        check("clip_writes", 32'(n_writes), 32'd9);

        // Largest brush.
        run(64, 64, C_YELLOW, 3);
`ifdef BRUSH_ROUND_EN
        check("r3_writes", 32'(n_writes), 32'd37);
`else
        check("r3_writes", 32'(n_writes), 32'd49);
`endif

        // Back-to-back: second request waits behind the first.
        n_writes = 0;
        issue(30, 40, C_RED, 2, ok);
        req_x      = 8'd90;
        req_y      = 8'd100;
        req_color  = C_BLUE;
        req_radius = RADIUS_W'(1);
        if (ok) tail(25, 1'b0);
        issue(90, 100, C_BLUE, 1, ok);
        if (ok) tail(9, 1'b1);

        // Reset on the 4th STAMP cycle of an r=2 stamp.
        issue(50, 50, C_YELLOW, 2, ok);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_brush", 32'(brush), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wx", 32'(wx), 32'd0);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        n_writes = 0;
        repeat (30) @(negedge clk);
        check("abort_no_residual", 32'(n_writes), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        // Randomised stamps, including centres off the canvas.
        for (int t = 0; t < 40; t++) begin
            run($urandom_range(0, 135), $urandom_range(0, 135),
                3'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
